rf_wb_ctrl: RTL
===============

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- NREQ, 3, number of writeback requesters; index 0 is EXU, 1 is LSU, 2 is MDU.
- XLEN, 64, data width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- core_clk  in  1  core clock; one clock domain only.
- core_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  writeback request per requester.
- req_ready  out  NREQ  grant; the request is accepted when valid and ready are both high at a posedge.
- req_rd  in  NREQ*5  destination register index, packed, requester i at bits [5i+4:5i].
- req_data  in  NREQ*XLEN  writeback data, packed.
- iss_valid  in  1  an instruction with destination iss_rd issues this cycle.
- iss_rd  in  5  destination register of the issuing instruction.
- flush  in  1  pipeline flush.
- rs1_addr, rs2_addr  in  5 each  source registers to check for hazards.
- rs1_busy, rs2_busy  out  1 each  the source register has a pending write.
- rf_wen  out  1  regfile write strobe; drives the regfile write-enable input.
- rf_waddr  out  5  regfile write address.
- rf_wdata  out  XLEN  regfile write data.

Function
REQ-003 SHALL assert at most one req_ready bit per cycle, combinationally, and only for a requester whose req_valid is high.
REQ-004 SHALL arbitrate round-robin: the search starts at (last_grant+1) mod NREQ; last_grant updates only on an accepted transfer.
REQ-005 SHALL register an accepted transfer so that rf_wen, rf_waddr and rf_wdata are valid the cycle after acceptance; the regfile commits at the following edge; throughput is one write per cycle.
REQ-006 SHALL accept a request with rd==0, keep rf_wen low for it, and still advance last_grant.
REQ-007 SHALL hold rf_wen low in any cycle with no accepted transfer in the previous cycle; rf_waddr and rf_wdata hold their last values.
REQ-008 SHALL keep a 32-bit scoreboard: iss_valid with iss_rd!=0 sets bit iss_rd; a commit (rf_wen high at a posedge) clears bit rf_waddr.
REQ-009 SHALL let the set win when a set and a clear hit the same index at the same edge.
REQ-010 SHALL tie scoreboard bit 0 to 0; rsN_busy SHALL equal scoreboard[rsN_addr].
REQ-011 SHALL make flush clear all scoreboard bits at the next edge, overriding any simultaneous set; an in-flight rf_wen write still commits.
REQ-012 SHALL not add a flush-cancel path: requesters drop req_valid themselves.

Reset
REQ-013 SHALL, while core_rst_n is low, force rf_wen=0, rf_waddr=0, rf_wdata=0, scoreboard=0 and last_grant=NREQ-1 (so requester 0 has first priority); req_ready SHALL be 0 during reset.
REQ-014 SHALL abandon any in-flight write when reset asserts mid-operation; no regfile write occurs.

Configuration
REQ-015 SHALL support macro RF_WB_BYPASS_EN.
- Defined: add outputs rs1_fwd and rs2_fwd (1 bit each) and rs1_fwd_data and rs2_fwd_data (XLEN each). rsN_fwd=rf_wen && rf_waddr==rsN_addr && rsN_addr!=0; rsN_fwd_data=rf_wdata. rsN_busy is masked low whenever rsN_fwd is high.
- Undefined: these ports are absent, and busy clears only after the commit edge.

Structure
REQ-016 SHALL place the constants NREQ, XLEN, REG_IDX_W=5 and the requester index enum (REQ_EXU=0, REQ_LSU=1, REQ_MDU=2) in the shared core defines package.
REQ-017 SHALL implement arbitration in one sub-module, rr_arb (parameter N; ports: valid, grant, advance), instanced once; the scoreboard stays inline.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- Single request: EXU valid, rd=5, data=0xDEAD at cycle 0 -> ready0=1 in cycle 0; rf_wen=1, waddr=5, wdata=0xDEAD in cycle 1.
- Contention: all three valid continuously from reset -> grants in order 0,1,2,0,1,2 on consecutive cycles; one rf_wen per cycle.
- x0 drop: LSU writes rd=0, data=0x1234 -> accepted; rf_wen stays 0; the next grant goes to requester 2.
- Scoreboard: iss rd=7 at cycle 0 -> rs1_addr=7 gives busy=1; EXU writes rd=7 at cycle 3 -> busy=0 from cycle 5 without the bypass macro, from cycle 4 with it (rs1_fwd=1, fwd_data=the written data).
- Set/clear collision: commit to rd=9 and iss rd=9 at the same edge -> bit 9 remains 1; flush at the next cycle -> all busy=0.
- Reset mid-operation: core_rst_n low while rf_wen=1 -> rf_wen=0 immediately, scoreboard=0, and the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared core defines for the writeback controller: requester count,
// data width, register index width and the requester index enum.
package rf_wb_ctrl_pkg;

    localparam int NREQ      = 3;
    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    // Writeback requester slots; the index is the bit position in req_valid/req_ready.
    typedef enum logic [1:0] {
        REQ_EXU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_MDU = 2'd2
    } req_idx_e;

endpackage

// File: rtl/rf_wb_ctrl_rr_arb.sv
// Round-robin arbiter. The search starts one slot past the last granted
// requester; the pointer only moves when the caller reports an accepted
// transfer through advance. Grants are forced low while rst_n is low.
module rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_r;
    logic [IW-1:0] grant_idx_s;
    logic [N-1:0]  grant_s;
    logic          found_s;
    int            idx_s;

    // Rotating priority search starting after the last winner.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = last_r;
        found_s     = 1'b0;
        idx_s       = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s = (int'(last_r) + k) % N;
            if (!found_s && valid[IW'(idx_s)]) begin
                found_s             = 1'b1;
                grant_s[IW'(idx_s)] = 1'b1;
                grant_idx_s         = IW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant = rst_n ? grant_s : '0;

    // Last-grant pointer; reset value N-1 gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= IW'(N - 1);
        end else if (advance) begin
            last_r <= grant_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: arbitrates EXU/LSU/MDU writebacks
// onto the single regfile write port (one registered write per cycle),
// drops writes to x0, and tracks pending destinations in a scoreboard.
// Optional feature macro RF_WB_BYPASS_EN adds forwarding of the write
// currently on the regfile port and masks busy for forwarded operands.
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int NREQ = rf_wb_ctrl_pkg::NREQ,
    parameter int XLEN = rf_wb_ctrl_pkg::XLEN
) (
    input  logic                 core_clk,
    input  logic                 core_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_rd,
    input  logic                 flush,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
`ifdef RF_WB_BYPASS_EN
    output logic                 rs1_fwd,
    output logic                 rs2_fwd,
    output logic [XLEN-1:0]      rs1_fwd_data,
    output logic [XLEN-1:0]      rs2_fwd_data,
`endif
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata
);

    logic [NREQ-1:0]      grant_s;
    logic                 accept_s;
    logic [REG_IDX_W-1:0] sel_rd_s;
    logic [XLEN-1:0]      sel_data_s;
    logic                 rf_wen_r;
    logic [REG_IDX_W-1:0] rf_waddr_r;
    logic [XLEN-1:0]      rf_wdata_r;
    logic [31:0]          sb_r;
    logic [31:0]          sb_nxt_s;

    rr_arb #(.N(NREQ)) u_rr_arb (
        .clk     (core_clk),
        .rst_n   (core_rst_n),
        .valid   (req_valid),
        .advance (accept_s),
        .grant   (grant_s)
    );

    // Grants only go to valid requesters, so any grant is an accepted transfer.
    assign req_ready = grant_s;
    assign accept_s  = |grant_s;

    // Select destination and data of the granted requester.
    always_comb begin
        sel_rd_s   = '0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_rd_s   = req_rd[i*REG_IDX_W +: REG_IDX_W];
                sel_data_s = req_data[i*XLEN +: XLEN];
            end else begin
                sel_rd_s   = sel_rd_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    // Regfile write port register; x0 writes are accepted but never strobed.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= '0;
        end else if (accept_s) begin
            rf_wen_r   <= (sel_rd_s != 5'd0);
            rf_waddr_r <= sel_rd_s;
            rf_wdata_r <= sel_data_s;
        end else begin
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= rf_waddr_r;
            rf_wdata_r <= rf_wdata_r;
        end
    end

    assign rf_wen   = rf_wen_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;

    // Scoreboard next state: flush beats everything, a set beats a same-index clear.
    always_comb begin
        sb_nxt_s = sb_r;
        if (flush) begin
            sb_nxt_s = 32'd0;
        end else begin
            if (rf_wen_r) begin
                sb_nxt_s[rf_waddr_r] = 1'b0;
            end else begin
                sb_nxt_s = sb_nxt_s;
            end
            if (iss_valid && (iss_rd != 5'd0)) begin
                sb_nxt_s[iss_rd] = 1'b1;
            end else begin
                sb_nxt_s = sb_nxt_s;
            end
        end
        sb_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            sb_r <= 32'd0;
        end else begin
            sb_r <= sb_nxt_s;
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd      = rf_wen_r && (rf_waddr_r == rs1_addr) && (rs1_addr != 5'd0);
    assign rs2_fwd      = rf_wen_r && (rf_waddr_r == rs2_addr) && (rs2_addr != 5'd0);
    assign rs1_fwd_data = rf_wdata_r;
    assign rs2_fwd_data = rf_wdata_r;
    assign rs1_busy     = sb_r[rs1_addr] & ~rs1_fwd;
    assign rs2_busy     = sb_r[rs2_addr] & ~rs2_fwd;
`else
    assign rs1_busy     = sb_r[rs1_addr];
    assign rs2_busy     = sb_r[rs2_addr];
`endif

endmodule
